// File: rtl/sdram_port_arbiter_if.sv
// sdram_port_arbiter_if
// Bundles the three requester ports (video, CPU, DMA) and the SDRAM
// controller request/response port that the arbiter sits between.
//   slave  : arbiter side (takes requests, drives acks, rdata and sd_*)
//   master : environment side (requesters plus SDRAM controller)
// Requester signals: *_req, *_addr, *_wr, *_wdata, *_dqm in; *_ack, rdata out.
// Controller signals: sd_req, sd_wr, sd_addr, sd_wdata, sd_dqm out;
//                     sd_ack, sd_done, sd_rdata in.
interface sdram_port_arbiter_if #(
  parameter int ADDR_W = 24
);
  logic              vid_req;
  logic              cpu_req;
  logic              dma_req;
  logic [ADDR_W-1:0] vid_addr;
  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] dma_addr;
  logic              cpu_wr;
  logic              dma_wr;
  logic [15:0]       cpu_wdata;
  logic [15:0]       dma_wdata;
  logic [1:0]        cpu_dqm;
  logic [1:0]        dma_dqm;
  logic              vid_ack;
  logic              cpu_ack;
  logic              dma_ack;
  logic [15:0]       rdata;

  logic              sd_req;
  logic              sd_wr;
  logic [ADDR_W-1:0] sd_addr;
  logic [15:0]       sd_wdata;
  logic [1:0]        sd_dqm;
  logic              sd_ack;
  logic              sd_done;
  logic [15:0]       sd_rdata;

  modport slave (
    input  vid_req, cpu_req, dma_req,
    input  vid_addr, cpu_addr, dma_addr,
    input  cpu_wr, dma_wr, cpu_wdata, dma_wdata, cpu_dqm, dma_dqm,
    output vid_ack, cpu_ack, dma_ack, rdata,
    output sd_req, sd_wr, sd_addr, sd_wdata, sd_dqm,
    input  sd_ack, sd_done, sd_rdata
  );

  modport master (
    output vid_req, cpu_req, dma_req,
    output vid_addr, cpu_addr, dma_addr,
    output cpu_wr, dma_wr, cpu_wdata, dma_wdata, cpu_dqm, dma_dqm,
    input  vid_ack, cpu_ack, dma_ack, rdata,
    input  sd_req, sd_wr, sd_addr, sd_wdata, sd_dqm,
    output sd_ack, sd_done, sd_rdata
  );
endinterface

// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one SDRAM controller request port between video fetch (fixed
// priority, read-only), the CPU and the SD/SPI DMA engine (round-robin
// between the two). A starvation counter caps consecutive video grants
// while CPU or DMA is waiting. One transaction in flight at a time.
// Ports:
//   clk   - system clock, rising edge
//   reset - synchronous, active-high
//   bus   - sdram_port_arbiter_if.slave (requester and controller signals)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | pick a winner from the sampled requests, load sd_* fields
// S_ISSUE  | sd_req high, fields frozen until the controller takes it
// S_WAIT   | request accepted, waiting for sd_done
// S_RETIRE | port ack and rdata valid for this one cycle
module sdram_port_arbiter #(
  parameter int ADDR_W       = 24,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  sdram_port_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RETIRE} state_t;
  typedef enum logic [1:0] {G_VID, G_CPU, G_DMA} gnt_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic              sd_req_q, sd_req_d;
  logic              sd_wr_q, sd_wr_d;
  logic [ADDR_W-1:0] sd_addr_q, sd_addr_d;
  logic [15:0]       sd_wdata_q, sd_wdata_d;
  logic [1:0]        sd_dqm_q, sd_dqm_d;
  logic [2:0]        ack_q, ack_d;       // {dma, cpu, vid}
  logic [15:0]       rdata_q, rdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              cpu_next_q, cpu_next_d;
  logic              other_pend;
  logic [2:0]        gnt_ack;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    sd_req_d   = sd_req_q;
    sd_wr_d    = sd_wr_q;
    sd_addr_d  = sd_addr_q;
    sd_wdata_d = sd_wdata_q;
    sd_dqm_d   = sd_dqm_q;
    ack_d      = 3'b000;
    rdata_d    = rdata_q;
    cnt_d      = cnt_q;
    cpu_next_d = cpu_next_q;
    other_pend = bus.cpu_req | bus.dma_req;

    case (gnt_q)
      G_VID:   gnt_ack = 3'b001;
      G_CPU:   gnt_ack = 3'b010;
      default: gnt_ack = 3'b100;
    endcase

    case (state_q)
      S_IDLE: begin
        if (bus.vid_req && (cnt_q < LIMIT || !other_pend)) begin
          gnt_d      = G_VID;
          sd_addr_d  = bus.vid_addr;
          sd_wr_d    = 1'b0;
          sd_wdata_d = '0;
          sd_dqm_d   = 2'b00;
          sd_req_d   = 1'b1;
          state_d    = S_ISSUE;
          // Only reachable with other_pend when cnt_q < LIMIT, so the
          // increment saturates at LIMIT by construction.
          if (other_pend) cnt_d = cnt_q + 8'd1;
        end else if (bus.cpu_req && (cpu_next_q || !bus.dma_req)) begin
          gnt_d      = G_CPU;
          sd_addr_d  = bus.cpu_addr;
          sd_wr_d    = bus.cpu_wr;
          sd_wdata_d = bus.cpu_wdata;
          sd_dqm_d   = bus.cpu_dqm;
          sd_req_d   = 1'b1;
          state_d    = S_ISSUE;
          cnt_d      = '0;
          cpu_next_d = 1'b0;
        end else if (bus.dma_req) begin
          gnt_d      = G_DMA;
          sd_addr_d  = bus.dma_addr;
          sd_wr_d    = bus.dma_wr;
          sd_wdata_d = bus.dma_wdata;
          sd_dqm_d   = bus.dma_dqm;
          sd_req_d   = 1'b1;
          state_d    = S_ISSUE;
          cnt_d      = '0;
          cpu_next_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (bus.sd_ack) begin
          sd_req_d = 1'b0;
          // Accept and completion in the same cycle skip WAIT entirely.
          if (bus.sd_done) begin
            rdata_d = bus.sd_rdata;
            ack_d   = gnt_ack;
            state_d = S_RETIRE;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (bus.sd_done) begin
          rdata_d = bus.sd_rdata;
          ack_d   = gnt_ack;
          state_d = S_RETIRE;
        end
      end
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= G_VID;
      sd_req_q   <= 1'b0;
      sd_wr_q    <= 1'b0;
      sd_addr_q  <= '0;
      sd_wdata_q <= '0;
      sd_dqm_q   <= 2'b11;
      ack_q      <= 3'b000;
      rdata_q    <= '0;
      cnt_q      <= '0;
      cpu_next_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      sd_req_q   <= sd_req_d;
      sd_wr_q    <= sd_wr_d;
      sd_addr_q  <= sd_addr_d;
      sd_wdata_q <= sd_wdata_d;
      sd_dqm_q   <= sd_dqm_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      cnt_q      <= cnt_d;
      cpu_next_q <= cpu_next_d;
    end
  end

  assign bus.sd_req   = sd_req_q;
  assign bus.sd_wr    = sd_wr_q;
  assign bus.sd_addr  = sd_addr_q;
  assign bus.sd_wdata = sd_wdata_q;
  assign bus.sd_dqm   = sd_dqm_q;
  assign bus.vid_ack  = ack_q[0];
  assign bus.cpu_ack  = ack_q[1];
  assign bus.dma_ack  = ack_q[2];
  assign bus.rdata    = rdata_q;

endmodule
